ascon_ctrl_fsm: RTL and testbench
=================================

ASCON_CTRL_FSM -- requirements
Module: ascon_ctrl_fsm

Interface
REQ-001 SHALL have parameter P_A_ROUNDS, default 12, rounds of init/final permutation (legal 1..16).
REQ-002 SHALL have parameter P_B_ROUNDS, default 6, rounds of AD/text permutation (legal 1..16; 8 for Ascon-128a).
REQ-003 SHALL have parameter P_BLK_W, default 8, width of block-count inputs.
REQ-004 clk_i  in  1  clock; single clock domain, all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  starts an operation; sampled only in IDLE.
REQ-007 decrypt_i  in  1  1 = decrypt, 0 = encrypt; latched at start.
REQ-008 nb_ad_i  in  P_BLK_W  number of associated-data blocks (0 allowed); latched at start.
REQ-009 nb_txt_i  in  P_BLK_W  number of text blocks including last padded block; latched at start.
REQ-010 data_valid_i  in  1  data block present on datapath.
REQ-011 abort_i  in  1  abort request (present only with ASCON_ABORT_EN).
REQ-012 data_ready_o  out  1  FSM waiting for a data block.
REQ-013 round_o  out  4  current round index within permutation.
REQ-014 sel_mux_perm_o  out  1  0 = permutation input from init vector, 1 = from state register.
REQ-015 sel_data_dec_o  out  1  select ciphertext as state replacement (decrypt).
REQ-016 we_state_o / we_cipher_o / we_tag_o  out  1 each  write enables for state, text-out, tag registers.
REQ-017 xor_begin_data_o / xor_begin_key_o / xor_end_key_o / xor_end_lsb_o  out  1 each  XOR injection enables.
REQ-018 busy_o  out  1  high in every state except IDLE.
REQ-019 done_o  out  1  one-cycle completion pulse.

Function
REQ-020 States: IDLE, INIT_PERM, AD_WAIT, AD_PERM, DOMSEP, TXT_WAIT, TXT_PERM, FIN_WAIT, FIN_PERM, DONE.
REQ-021 IDLE: start_i=1 latches decrypt_i, nb_ad_i, nb_txt_i, goes to INIT_PERM with round 0; start_i in any other state ignored.
REQ-022 *_PERM states last exactly N cycles (N = P_A_ROUNDS for INIT/FIN, P_B_ROUNDS for AD/TXT), round_o 0..N-1, we_state_o=1 every cycle.
REQ-023 INIT_PERM: sel_mux_perm_o=0 at round 0, 1 otherwise; xor_end_key_o=1 at round N-1; exit to AD_WAIT if nb_ad>0 else DOMSEP.
REQ-024 *_WAIT: data_ready_o=1, outputs otherwise 0; data_valid_i=1 moves to the matching *_PERM; data_valid_i outside WAIT states ignored.
REQ-025 AD_PERM round 0: xor_begin_data_o=1; after last round, decrement AD counter, go to AD_WAIT if blocks remain else DOMSEP.
REQ-026 DOMSEP: one cycle, xor_end_lsb_o=1, we_state_o=1; then TXT_WAIT if nb_txt>1 else FIN_WAIT.
REQ-027 TXT_PERM round 0: xor_begin_data_o=1, we_cipher_o=1, sel_data_dec_o=decrypt; after last round go to TXT_WAIT while more than one text block remains, else FIN_WAIT.
REQ-028 FIN_PERM round 0: xor_begin_data_o, xor_begin_key_o, we_cipher_o =1, sel_data_dec_o=decrypt; round N-1: xor_end_key_o=1, we_tag_o=1.
REQ-029 DONE: done_o=1 for one cycle, then IDLE.
REQ-030 nb_txt_i=0 SHALL be treated as 1 (single padding block).
REQ-031 Block counters P_BLK_W wide, decrement only, never wrap below 0; round counter clears on every PERM entry.
REQ-032 sel_mux_perm_o=1 in all PERM rounds except INIT round 0.
REQ-033 All outputs registered-state decoded (Moore); no output depends combinationally on inputs.

Reset
REQ-034 rst_i=1 at a rising edge forces IDLE, clears counters and latched config, regardless of state (including mid-permutation).
REQ-035 Reset value of every output is 0.

Configuration
REQ-036 Macro ASCON_ABORT_EN defined: abort_i port exists; abort_i=1 in any non-IDLE state returns to IDLE next cycle, no done_o, counters cleared; abort takes priority over data_valid_i.
REQ-037 Macro undefined: no abort_i port, operation always runs to DONE.

Structure
REQ-038 State enum typedef and default round constants (12, 6) SHALL live in ascon_pack.
REQ-039 Round counter SHALL be sub-module ascon_round_cnt (clear, enable, terminal-count output).

Verification
REQ-040 Defaults, nb_ad=1, nb_txt=2, data_valid_i held 1, start at cycle 0 -> INIT 1..12, DOMSEP at 20, done_o pulse at cycle 41.
REQ-041 nb_ad=0, nb_txt=1 -> INIT then DOMSEP directly, FIN_PERM entered, no AD_PERM/TXT_PERM cycles, we_tag_o once.
REQ-042 decrypt_i=1, nb_txt=3 -> sel_data_dec_o=1 exactly 3 times (2 TXT, 1 FIN round 0), we_cipher_o 3 pulses.
REQ-043 data_valid_i low 5 cycles in TXT_WAIT -> FSM holds, data_ready_o high 5 cycles, total latency +5.
REQ-044 rst_i at round 3 of AD_PERM -> next cycle IDLE, all outputs 0; start_i during busy ignored.
REQ-045 With ASCON_ABORT_EN, abort_i in FIN_PERM round 5 -> IDLE next cycle, done_o never asserted.

Source files
------------

// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pack (package)
// Description : Shared types and constants for the Ascon control FSM:
//               controller state encoding and default round counts.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pack;

   // Default permutation round counts (Ascon-128: a = 12, b = 6).
   localparam int unsigned c_A_ROUNDS_DEF = 12;
   localparam int unsigned c_B_ROUNDS_DEF = 6;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_INIT_PERM = 4'd1,
      ST_AD_WAIT   = 4'd2,
      ST_AD_PERM   = 4'd3,
      ST_DOMSEP    = 4'd4,
      ST_TXT_WAIT  = 4'd5,
      ST_TXT_PERM  = 4'd6,
      ST_FIN_WAIT  = 4'd7,
      ST_FIN_PERM  = 4'd8,
      ST_DONE      = 4'd9
   } ascon_state_t;

endpackage
`default_nettype wire

// File: rtl/ascon_round_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ascon_round_cnt
// Description : 4-bit permutation round counter with synchronous clear,
//               count enable and terminal-count flag (count == last_i).
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset
//               clear_i - force count to 0 on next edge (priority over en_i)
//               en_i    - increment count
//               last_i  - terminal round index (N-1)
//               cnt_o   - current round index
//               tc_o    - high while cnt_o == last_i
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_round_cnt (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       en_i,
   input  logic [3:0] last_i,
   output logic [3:0] cnt_o,
   output logic       tc_o
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_cnt <= 4'd0;
      end else if (en_i) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign cnt_o = r_cnt;
   assign tc_o  = (r_cnt == last_i);

endmodule
`default_nettype wire

// File: rtl/ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ascon_ctrl_fsm
// Description : Control FSM for an Ascon AEAD datapath. Sequences the
//               initialisation permutation, associated-data blocks, domain
//               separation, text blocks and the finalisation permutation,
//               driving Moore-decoded datapath enables.
// Options     : ASCON_ABORT_EN - adds abort_i; abort returns to IDLE.
// Ports       : clk_i, rst_i (sync, active-high)
//               start_i, decrypt_i, nb_ad_i, nb_txt_i - operation request
//               data_valid_i   - data block present
//               abort_i        - abort request (ASCON_ABORT_EN only)
//               data_ready_o   - waiting for a data block
//               round_o        - round index within current permutation
//               sel_mux_perm_o, sel_data_dec_o - datapath selects
//               we_state_o, we_cipher_o, we_tag_o - register write enables
//               xor_begin_data_o, xor_begin_key_o, xor_end_key_o,
//               xor_end_lsb_o  - XOR injection enables
//               busy_o, done_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_ctrl_fsm
   import ascon_pack::*;
#(
   parameter int unsigned P_A_ROUNDS = c_A_ROUNDS_DEF,
   parameter int unsigned P_B_ROUNDS = c_B_ROUNDS_DEF,
   parameter int unsigned P_BLK_W    = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               decrypt_i,
   input  logic [P_BLK_W-1:0] nb_ad_i,
   input  logic [P_BLK_W-1:0] nb_txt_i,
   input  logic               data_valid_i,
`ifdef ASCON_ABORT_EN
   input  logic               abort_i,
`endif
   output logic               data_ready_o,
   output logic [3:0]         round_o,
   output logic               sel_mux_perm_o,
   output logic               sel_data_dec_o,
   output logic               we_state_o,
   output logic               we_cipher_o,
   output logic               we_tag_o,
   output logic               xor_begin_data_o,
   output logic               xor_begin_key_o,
   output logic               xor_end_key_o,
   output logic               xor_end_lsb_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam logic [3:0] c_A_LAST = 4'(P_A_ROUNDS - 1);
   localparam logic [3:0] c_B_LAST = 4'(P_B_ROUNDS - 1);

   ascon_state_t       r_state;
   ascon_state_t       w_next_state;
   logic               r_decrypt;
   logic [P_BLK_W-1:0] r_ad_cnt;
   logic [P_BLK_W-1:0] r_txt_cnt;
   logic [3:0]         w_round;
   logic [3:0]         w_last;
   logic               w_tc;
   logic               w_in_perm;
   logic               w_a_perm;
   logic               w_first;
   logic               w_abort;

`ifdef ASCON_ABORT_EN
   assign w_abort = abort_i && (r_state != ST_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   assign w_a_perm  = (r_state == ST_INIT_PERM) || (r_state == ST_FIN_PERM);
   assign w_in_perm = w_a_perm || (r_state == ST_AD_PERM) || (r_state == ST_TXT_PERM);
   assign w_last    = w_a_perm ? c_A_LAST : c_B_LAST;
   assign w_first   = (w_round == 4'd0);

   // Held at zero outside permutations and cleared on the last round, so
   // every permutation entry starts at round 0.
   ascon_round_cnt u_round_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (w_abort || !w_in_perm || w_tc),
      .en_i    (w_in_perm),
      .last_i  (w_last),
      .cnt_o   (w_round),
      .tc_o    (w_tc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Latched configuration and block counters.
   always_ff @(posedge clk_i) begin
      if (rst_i || w_abort) begin
         r_decrypt <= 1'b0;
         r_ad_cnt  <= '0;
         r_txt_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_decrypt <= decrypt_i;
                  r_ad_cnt  <= nb_ad_i;
                  // A zero text count still needs the single padding block.
                  r_txt_cnt <= (nb_txt_i == '0) ? P_BLK_W'(1) : nb_txt_i;
               end
            end
            ST_AD_PERM: begin
               if (w_tc && (r_ad_cnt != '0)) r_ad_cnt <= r_ad_cnt - 1'b1;
            end
            ST_TXT_PERM: begin
               if (w_tc && (r_txt_cnt != '0)) r_txt_cnt <= r_txt_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state     = r_state;
      data_ready_o     = 1'b0;
      sel_mux_perm_o   = 1'b0;
      sel_data_dec_o   = 1'b0;
      we_state_o       = 1'b0;
      we_cipher_o      = 1'b0;
      we_tag_o         = 1'b0;
      xor_begin_data_o = 1'b0;
      xor_begin_key_o  = 1'b0;
      xor_end_key_o    = 1'b0;
      xor_end_lsb_o    = 1'b0;
      done_o           = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start_i) w_next_state = ST_INIT_PERM;
         end
         ST_INIT_PERM: begin
            we_state_o     = 1'b1;
            sel_mux_perm_o = !w_first;
            if (w_tc) begin
               xor_end_key_o = 1'b1;
               w_next_state  = (r_ad_cnt != '0) ? ST_AD_WAIT : ST_DOMSEP;
            end
         end
         ST_AD_WAIT: begin
            data_ready_o = 1'b1;
            if (data_valid_i) w_next_state = ST_AD_PERM;
         end
         ST_AD_PERM: begin
            we_state_o       = 1'b1;
            sel_mux_perm_o   = 1'b1;
            xor_begin_data_o = w_first;
            // Counter still holds the pre-decrement value here.
            if (w_tc) w_next_state = (int'(r_ad_cnt) > 1) ? ST_AD_WAIT : ST_DOMSEP;
         end
         ST_DOMSEP: begin
            we_state_o    = 1'b1;
            xor_end_lsb_o = 1'b1;
            w_next_state  = (int'(r_txt_cnt) > 1) ? ST_TXT_WAIT : ST_FIN_WAIT;
         end
         ST_TXT_WAIT: begin
            data_ready_o = 1'b1;
            if (data_valid_i) w_next_state = ST_TXT_PERM;
         end
         ST_TXT_PERM: begin
            we_state_o       = 1'b1;
            sel_mux_perm_o   = 1'b1;
            xor_begin_data_o = w_first;
            we_cipher_o      = w_first;
            sel_data_dec_o   = w_first && r_decrypt;
            // The last text block is absorbed by the finalisation step.
            if (w_tc) w_next_state = (int'(r_txt_cnt) > 2) ? ST_TXT_WAIT : ST_FIN_WAIT;
         end
         ST_FIN_WAIT: begin
            data_ready_o = 1'b1;
            if (data_valid_i) w_next_state = ST_FIN_PERM;
         end
         ST_FIN_PERM: begin
            we_state_o       = 1'b1;
            sel_mux_perm_o   = 1'b1;
            xor_begin_data_o = w_first;
            xor_begin_key_o  = w_first;
            we_cipher_o      = w_first;
            sel_data_dec_o   = w_first && r_decrypt;
            if (w_tc) begin
               xor_end_key_o = 1'b1;
               we_tag_o      = 1'b1;
               w_next_state  = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase

      if (w_abort) w_next_state = ST_IDLE;
   end

   assign busy_o  = (r_state != ST_IDLE);
   assign round_o = w_round;

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_ctrl_fsm
// Description : Self-checking bench for ascon_ctrl_fsm. A step-queue model
//               predicts every output each cycle; directed runs pin cycle
//               positions and pulse counts with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_ctrl_fsm;

   localparam int A = 12;
   localparam int B = 6;
   localparam int W = 8;

   localparam int K_INIT = 0, K_WAIT = 1, K_ADP = 2, K_DOM = 3,
                  K_TXTP = 4, K_FINP = 5, K_DONE = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, decrypt, data_valid;
   logic [W-1:0] nb_ad, nb_txt;
`ifdef ASCON_ABORT_EN
   logic         abort;
`endif
   logic         data_ready, sel_mux, sel_dec, we_state, we_cipher, we_tag;
   logic         xbd, xbk, xek, xel, busy, done;
   logic [3:0]   round;
   logic [15:0]  dut_vec;

   ascon_ctrl_fsm #(.P_A_ROUNDS(A), .P_B_ROUNDS(B), .P_BLK_W(W)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .decrypt_i        (decrypt),
      .nb_ad_i          (nb_ad),
      .nb_txt_i         (nb_txt),
      .data_valid_i     (data_valid),
`ifdef ASCON_ABORT_EN
      .abort_i          (abort),
`endif
      .data_ready_o     (data_ready),
      .round_o          (round),
      .sel_mux_perm_o   (sel_mux),
      .sel_data_dec_o   (sel_dec),
      .we_state_o       (we_state),
      .we_cipher_o      (we_cipher),
      .we_tag_o         (we_tag),
      .xor_begin_data_o (xbd),
      .xor_begin_key_o  (xbk),
      .xor_end_key_o    (xek),
      .xor_end_lsb_o    (xel),
      .busy_o           (busy),
      .done_o           (done)
   );

   assign dut_vec = {busy, done, data_ready, round, sel_mux, sel_dec, we_state,
                     we_cipher, we_tag, xbd, xbk, xek, xel};

   // ---------------- behavioural model: queue of per-cycle steps ----------
   typedef struct {
      int kind;
      int rnd;
      bit last;
   } step_t;

   step_t mq[$];
   bit    m_dec = 1'b0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    chk_en = 1'b0;

   function automatic void push_perm(input int kind, input int n);
      step_t s;
      for (int r = 0; r < n; r++) begin
         s.kind = kind; s.rnd = r; s.last = (r == n - 1);
         mq.push_back(s);
      end
   endfunction

   function automatic void push_one(input int kind);
      step_t s;
      s.kind = kind; s.rnd = 0; s.last = 1'b0;
      mq.push_back(s);
   endfunction

   function automatic void plan(input bit dec, input int nad, input int ntxt);
      int nt;
      m_dec = dec;
      nt = (ntxt == 0) ? 1 : ntxt;
      push_perm(K_INIT, A);
      for (int i = 0; i < nad; i++) begin
         push_one(K_WAIT); push_perm(K_ADP, B);
      end
      push_one(K_DOM);
      for (int i = 0; i < nt - 1; i++) begin
         push_one(K_WAIT); push_perm(K_TXTP, B);
      end
      push_one(K_WAIT); push_perm(K_FINP, A);
      push_one(K_DONE);
   endfunction

   function automatic logic [15:0] model_vec();
      step_t s;
      bit perm, first, din, ciph;
      if (mq.size() == 0) return 16'h0000;
      s     = mq[0];
      perm  = (s.kind == K_INIT) || (s.kind == K_ADP) || (s.kind == K_TXTP) || (s.kind == K_FINP);
      first = perm && (s.rnd == 0);
      din   = first && (s.kind != K_INIT);
      ciph  = first && ((s.kind == K_TXTP) || (s.kind == K_FINP));
      return {1'b1, (s.kind == K_DONE), (s.kind == K_WAIT),
              perm ? 4'(s.rnd) : 4'd0,
              perm && !(s.kind == K_INIT && s.rnd == 0),
              ciph && m_dec,
              perm || (s.kind == K_DOM),
              ciph,
              (s.kind == K_FINP) && s.last,
              din,
              first && (s.kind == K_FINP),
              ((s.kind == K_INIT) || (s.kind == K_FINP)) && s.last,
              (s.kind == K_DOM)};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_dec = 1'b0;
      end
`ifdef ASCON_ABORT_EN
      else if (abort && mq.size() != 0) begin
         mq.delete();
      end
`endif
      else if (mq.size() == 0) begin
         if (start) plan(decrypt, int'(nb_ad), int'(nb_txt));
      end else if (!(mq[0].kind == K_WAIT && !data_valid)) begin
         void'(mq.pop_front());
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) chk("cycle_outputs", dut_vec, model_vec());
   end

   // ---------------- directed operation runner ---------------------------
   int r_dom, r_done, r_endkey, r_kill_round, r_after_kill;
   int n_tag, n_dec, n_cipher, n_ready, n_done, n_bdata;
   bit g_kill_abort = 1'b0;

   task automatic run_op(input bit dec, input int nad, input int ntxt,
                         input int stall_len, input int kill_at, input bit poke);
      bit finished;
      finished = 1'b0;
      r_dom = -1; r_done = -1; r_endkey = -1; r_kill_round = -1; r_after_kill = -1;
      n_tag = 0; n_dec = 0; n_cipher = 0; n_ready = 0; n_done = 0; n_bdata = 0;
      @(negedge clk);
      decrypt = dec; nb_ad = W'(nad); nb_txt = W'(ntxt);
      start = 1'b1; data_valid = 1'b1;
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         if (xel && r_dom < 0) r_dom = k;
         if (done && r_done < 0) r_done = k;
         if (xek && r_endkey < 0) r_endkey = k;
         if (k == kill_at) r_kill_round = int'(round);
         if (k == kill_at + 1) r_after_kill = int'(dut_vec);
         n_tag += int'(we_tag); n_dec += int'(sel_dec); n_cipher += int'(we_cipher);
         n_ready += int'(data_ready); n_done += int'(done); n_bdata += int'(xbd);
         if (!busy) begin
            finished = 1'b1;
            break;
         end
         start      = poke && (k == 5);
         data_valid = !(stall_len > 0 && k >= 21 && k < 21 + stall_len);
         rst        = (k == kill_at) && !g_kill_abort;
`ifdef ASCON_ABORT_EN
         abort      = (k == kill_at) && g_kill_abort;
`endif
      end
      start = 1'b0; data_valid = 1'b0; rst = 1'b0;
`ifdef ASCON_ABORT_EN
      abort = 1'b0;
`endif
      chk_i("op_terminates", int'(finished), 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; decrypt = 1'b0; data_valid = 1'b0;
      nb_ad = '0; nb_txt = '0;
`ifdef ASCON_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset_outputs", dut_vec, 16'h0000);
      chk_en = 1'b1;
      rst = 1'b0;

      // Defaults, 1 AD block, 2 text blocks, valid held high.
      run_op(1'b0, 1, 2, 0, -1, 1'b0);
      chk_i("init_endkey_cycle", r_endkey, 12);
      chk_i("domsep_cycle", r_dom, 20);
      chk_i("done_cycle", r_done, 41);
      chk_i("tag_pulses", n_tag, 1);
      chk_i("done_pulses", n_done, 1);

      // No AD, single text block: straight to finalisation.
      run_op(1'b0, 0, 1, 0, -1, 1'b0);
      chk_i("domsep_cycle_noad", r_dom, 13);
      chk_i("begin_data_noad", n_bdata, 1);
      chk_i("tag_pulses_noad", n_tag, 1);
      chk_i("done_cycle_noad", r_done, 27);

      // nb_txt = 0 behaves as one block.
      run_op(1'b0, 0, 0, 0, -1, 1'b0);
      chk_i("done_cycle_txt0", r_done, 27);

      // Decrypt with three text blocks.
      run_op(1'b1, 0, 3, 0, -1, 1'b0);
      chk_i("dec_select_pulses", n_dec, 3);
      chk_i("cipher_we_pulses", n_cipher, 3);

      // Five-cycle stall in TXT_WAIT, plus an ignored start while busy.
      run_op(1'b0, 1, 2, 5, -1, 1'b1);
      chk_i("ready_cycles_stall", n_ready, 8);
      chk_i("done_cycle_stall", r_done, 46);

      // Reset in round 3 of the AD permutation.
      run_op(1'b0, 1, 2, 0, 17, 1'b0);
      chk_i("round_at_reset", r_kill_round, 3);
      chk_i("outputs_after_reset", r_after_kill, 0);
      chk_i("no_done_after_reset", n_done, 0);

`ifdef ASCON_ABORT_EN
      // Abort in round 5 of the finalisation permutation.
      g_kill_abort = 1'b1;
      run_op(1'b0, 1, 2, 0, 34, 1'b0);
      g_kill_abort = 1'b0;
      chk_i("round_at_abort", r_kill_round, 5);
      chk_i("outputs_after_abort", r_after_kill, 0);
      chk_i("no_done_after_abort", n_done, 0);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start      = ($urandom_range(0, 7) == 0);
         decrypt    = 1'($urandom);
         nb_ad      = W'($urandom_range(0, 3));
         nb_txt     = W'($urandom_range(0, 4));
         data_valid = ($urandom_range(0, 3) != 0);
         rst        = ($urandom_range(0, 399) == 0);
`ifdef ASCON_ABORT_EN
         abort      = ($urandom_range(0, 299) == 0);
`endif
      end
      @(negedge clk);
      start = 1'b0; data_valid = 1'b0; rst = 1'b0;
`ifdef ASCON_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
